// File: rtl/ram_access_sched.sv
// Single-port RAM access scheduler: arbitrates a FIFO-style producer and consumer onto one RAM.
// Define RAM_SCHED_WRPRIO_EN for fixed write priority; default build uses round-robin arbitration.
module ram_access_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclr,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  rd_valid_q;
  logic                  clr;
  logic                  wr_elig, rd_elig, wr_win;
  logic                  grant_wr, grant_rd;

  assign clr   = reset | sclr;
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;

  assign wr_elig = wr_req & ~full;
  assign rd_elig = rd_req & ~empty;

`ifdef RAM_SCHED_WRPRIO_EN
  assign wr_win = 1'b1;
`else
  // wr_turn_q: write owns the next contended cycle
  logic wr_turn_q, wr_turn_d;
  assign wr_win = wr_turn_q;

  always_comb begin
    wr_turn_d = wr_turn_q;
    if (wr_elig && rd_elig) wr_turn_d = ~grant_wr;
  end

  always_ff @(posedge clk) begin
    if (clr) wr_turn_q <= 1'b1;
    else     wr_turn_q <= wr_turn_d;
  end
`endif

  // Full/empty already removed the blocked side from eligibility, so the
  // no-bypass cases never look contended and leave the arbiter alone.
  assign grant_wr = ~clr & wr_elig & (~rd_elig | wr_win);
  assign grant_rd = ~clr & rd_elig & ~(wr_elig & wr_win);

  assign wr_ack  = grant_wr;
  assign rd_ack  = grant_rd;
  assign ram_din = wr_data;
  assign rd_data = ram_dout;
  // Masked during clear so a read issued just before reset never reports valid.
  assign rd_valid = rd_valid_q & ~clr;

  always_comb begin
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant_wr) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end else if (grant_rd) begin
      ram_en   = 1'b1;
      ram_addr = rd_ptr_q;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d  = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= grant_rd;
    end
  end

endmodule

// File: tb/tb_ram_access_sched.sv
// Directed bench for ram_access_sched with a behavioural RAM and a FIFO scoreboard of written data.
module tb_ram_access_sched;
  logic       clk = 1'b0;
  logic       reset, sclr, wr_req, rd_req;
  logic [7:0] wr_data;
  logic       wr_ack, rd_ack, rd_valid, ram_en, ram_we, full, empty;
  logic [7:0] rd_data, ram_din, ram_dout;
  logic [2:0] ram_addr;
  logic [3:0] count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         mwp, mrp;
  logic       exp_rv;
  logic [7:0] exp_rd;
  logic [7:0] mem [0:7];
  int         pw [0:5];

  ram_access_sched dut (
    .clk(clk), .reset(reset), .sclr(sclr),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input logic ew, input logic er);
    wr_req = w; rd_req = r; wr_data = d;
    @(negedge clk);
    chk("count", {28'd0, count}, sb.size());
    chk("full", {31'd0, full}, (sb.size() == 8) ? 1 : 0);
    chk("empty", {31'd0, empty}, (sb.size() == 0) ? 1 : 0);
    chk("wr_ack", {31'd0, wr_ack}, {31'd0, ew});
    chk("rd_ack", {31'd0, rd_ack}, {31'd0, er});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, exp_rv});
    if (exp_rv) chk("rd_data", {24'd0, rd_data}, {24'd0, exp_rd});
    if (ew) begin
      chk("wr_addr", {29'd0, ram_addr}, mwp);
      chk("wr_en_we", {30'd0, ram_en, ram_we}, 32'd3);
      chk("ram_din", {24'd0, ram_din}, {24'd0, d});
      sb.push_back(d);
      mwp = (mwp + 1) % 8;
    end else if (er) begin
      chk("rd_addr", {29'd0, ram_addr}, mrp);
      chk("rd_en_we", {30'd0, ram_en, ram_we}, 32'd2);
      if (sb.size() > 0) exp_rd = sb.pop_front();
      else begin
        errors++;
        $display("FAIL scoreboard_underflow: read granted with no stored data");
      end
      mrp = (mrp + 1) % 8;
    end else begin
      chk("idle_bus", {27'd0, ram_en, ram_we, ram_addr}, 32'd0);
    end
    exp_rv = er;
    @(posedge clk); #1;
  endtask

  task automatic rst_cyc(input logic use_sclr);
    reset = ~use_sclr; sclr = use_sclr; wr_req = 1'b1; rd_req = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    chk("rst_acks", {30'd0, wr_ack, rd_ack}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; sclr = 1'b0;
    sb.delete(); mwp = 0; mrp = 0; exp_rv = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sclr = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = 8'h00;
    exp_rv = 1'b0; exp_rd = 8'h00; mwp = 0; mrp = 0;
`ifdef RAM_SCHED_WRPRIO_EN
    pw = '{1, 1, 1, 1, 0, 1};
`else
    pw = '{1, 0, 1, 0, 1, 0};
`endif
    rst_cyc(1'b0);
    rst_cyc(1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill to full, then a blocked write
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i), 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    // Drain in order, then a blocked read
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    // Empty with both requesting: write wins, then build to count 4
    cyc(1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i), 1'b1, 1'b0);
    // Contended stretch from count 4
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 8'($urandom_range(0, 255)), pw[i] != 0, pw[i] == 0);
    drain();

    // Full with both requesting: read wins without touching arbitration
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i), 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 8'h40, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 8'h41, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
`ifdef RAM_SCHED_WRPRIO_EN
    cyc(1'b1, 1'b1, 8'h42, 1'b1, 1'b0);
`else
    cyc(1'b1, 1'b1, 8'h42, 1'b0, 1'b1);
`endif
    drain();

    // Pointer wrap: 5 writes, 5 reads, 5 writes, drain
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h50 + 8'(i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h60 + 8'(i), 1'b1, 1'b0);
    drain();

    // sclr right after a read grant
    cyc(1'b1, 1'b0, 8'h71, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h72, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    rst_cyc(1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h73, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_access_sched.md
RAM_ACCESS_SCHED -- requirements
Module: ram_access_sched

Interface
- REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
- REQ-002: Parameter ADDR_WIDTH, default 3, SHALL set the RAM address width; DEPTH = 2**ADDR_WIDTH.
- REQ-003: clk, input, 1: single clock; all state SHALL update on its rising edge.
- REQ-004: reset, input, 1: synchronous, active-high reset.
- REQ-005: sclr, input, 1: synchronous clear, same effect as reset.
- REQ-006: wr_req, input, 1: level write request from the producer.
- REQ-007: wr_data, input, DATA_WIDTH: write data, sampled in the wr_ack cycle.
- REQ-008: wr_ack, output, 1: one-cycle pulse; the write is performed this cycle.
- REQ-009: rd_req, input, 1: level read request from the consumer.
- REQ-010: rd_ack, output, 1: one-cycle pulse; the RAM read is issued this cycle.
- REQ-011: rd_data, output, DATA_WIDTH: equals ram_dout.
- REQ-012: rd_valid, output, 1: rd_data is valid; asserted exactly one cycle after rd_ack.
- REQ-013: ram_en, ram_we, output, 1 each: RAM enable and write-enable (1 = write).
- REQ-014: ram_addr, output, ADDR_WIDTH: RAM address.
- REQ-015: ram_din, output, DATA_WIDTH: RAM write data; equals wr_data.
- REQ-016: ram_dout, input, DATA_WIDTH: RAM read data, registered one cycle after the read.
- REQ-017: count, output, ADDR_WIDTH+1: number of stored words, 0..DEPTH.
- REQ-018: full, empty, output, 1 each: full = (count == DEPTH); empty = (count == 0).

Function
- REQ-019: The block SHALL be the only RAM master and SHALL issue at most one RAM access, read or write, per cycle.
- REQ-020: A write SHALL be eligible when wr_req=1 and full=0; a read SHALL be eligible when rd_req=1 and empty=0.
- REQ-021: With one eligible request, that request SHALL be granted in the same cycle (combinational ack).
- REQ-022: With both eligible, the grant SHALL go to the side not granted in the last contended cycle (round-robin); after reset, write wins first.
- REQ-023: Write grant: ram_en=1, ram_we=1, ram_addr=wr_ptr, wr_ack=1; wr_ptr SHALL increment modulo DEPTH.
- REQ-024: Read grant: ram_en=1, ram_we=0, ram_addr=rd_ptr, rd_ack=1; rd_ptr SHALL increment modulo DEPTH.
- REQ-025: No grant: ram_en=0, ram_we=0, ram_addr=0, both acks 0.
- REQ-026: count SHALL increment by 1 on a write grant, decrement by 1 on a read grant, and otherwise hold.
- REQ-027: All DEPTH entries SHALL be usable; pointer wrap SHALL NOT alter count.
- REQ-028: When full and both requests are present, the read SHALL be granted; when empty and both are present, the write SHALL be granted (no bypass); neither case SHALL update the round-robin state.
- REQ-029: Requests blocked by full/empty SHALL produce no ack and no state change.

Reset
- REQ-030: reset or sclr SHALL clear wr_ptr, rd_ptr, count and rd_valid to 0, and set round-robin to write-first, on the next edge.
- REQ-031: During reset/sclr, all acks and ram_en SHALL be 0; a read issued the cycle before reset SHALL NOT raise rd_valid.

Configuration
- REQ-032: Macro RAM_SCHED_WRPRIO_EN: when defined, a contended cycle SHALL always grant the write (fixed write priority) and round-robin state SHALL be removed; when undefined, REQ-022 applies.

Verification
- REQ-033: Reset, then 8 writes 0x10..0x17 with rd_req=0 -> 8 wr_acks, count=8, full=1; a 9th wr_req -> no wr_ack.
- REQ-034: From full, 8 reads -> rd_data 0x10..0x17 in order, each with rd_valid one cycle after rd_ack; then empty=1.
- REQ-035: count=4, wr_req=rd_req=1 for 6 cycles -> grants alternate W,R,W,R,W,R; count stays 4-5.
- REQ-036: Wrap: 5 writes, 5 reads, 5 writes -> ram_addr passes 7->0, and data reads back in order.
- REQ-037: Assert sclr the cycle after a rd_ack -> rd_valid=0, count=0, empty=1 on the next cycle.
- REQ-038: With RAM_SCHED_WRPRIO_EN defined, count=4 and both requests held -> writes only, until full, then reads.
